// File: rtl/ysyx_bus_sched_pkg.sv
// Shared bus definitions: scheduler FSM states, starvation default, AXI size helper.
package ysyx_bus_sched_pkg;

    localparam int unsigned StarveMaxDefault = 4;

    typedef enum logic [2:0] {
        StIdle,
        StAr,
        StR,
        StAww,
        StB
    } bus_state_e;

    // AXI size (log2 bytes) from an LSB-aligned byte mask; unknown masks map to a word.
    function automatic logic [2:0] size_from_strb(input logic [3:0] strb);
        case (strb)
            4'h1:    return 3'd0;
            4'h3:    return 3'd1;
            default: return 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_bus_sched.sv
// Two-requester (IFU/LSU) scheduler onto a single 64-bit AXI master, one transaction in flight.
module ysyx_bus_sched
    import ysyx_bus_sched_pkg::*;
#(
    parameter int unsigned STARVE_MAX = StarveMaxDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ifu_addr,
    input  logic        ifu_valid,
    output logic        ifu_done_o,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_valid,
    input  logic        lsu_we,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_strb,
    output logic        lsu_done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [31:0] io_master_araddr,
    output logic [2:0]  io_master_arsize,
    output logic        io_master_arvalid,
    input  logic        io_master_arready,
    input  logic [63:0] io_master_rdata,
    input  logic [1:0]  io_master_rresp,
    input  logic        io_master_rvalid,
    output logic        io_master_rready,
    output logic [31:0] io_master_awaddr,
    output logic [2:0]  io_master_awsize,
    output logic        io_master_awvalid,
    input  logic        io_master_awready,
    output logic [63:0] io_master_wdata,
    output logic [7:0]  io_master_wstrb,
    output logic        io_master_wlast,
    output logic        io_master_wvalid,
    input  logic        io_master_wready,
    input  logic [1:0]  io_master_bresp,
    input  logic        io_master_bvalid,
    output logic        io_master_bready
);

    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

    bus_state_e      state_q;
    logic [CntW-1:0] starve_q;
    logic            lsu_sel_q;   // 1 = current transaction belongs to the LSU
    logic [31:0]     addr_q;
    logic            we_q;
    logic [31:0]     wdata_q;
    logic [3:0]      strb_q;
    logic            awvalid_q;
    logic            wvalid_q;
    logic            ifu_done_q;
    logic            lsu_done_q;
    logic [31:0]     rdata_q;
    logic            err_q;

    logic        lsu_win;
    logic        ifu_win;
    logic        may_grant;
    logic        aw_done;
    logic        w_done;
    logic [31:0] lane;
    logic [3:0]  strb_sh;

    // Arbitration: LSU first unless it has starved a waiting IFU for STARVE_MAX grants.
    always_comb begin
        lsu_win   = lsu_valid && (!ifu_valid || (starve_q < StarveMax));
        ifu_win   = ifu_valid && !lsu_win;
        // No grant while a done pulse is out, so the finished requester can drop valid.
        may_grant = !ifu_done_q && !lsu_done_q;
        aw_done   = !awvalid_q || io_master_awready;
        w_done    = !wvalid_q || io_master_wready;
        lane      = wdata_q << {addr_q[1:0], 3'b000};
        strb_sh   = strb_q << addr_q[1:0];
    end

    // Scheduler FSM with latched request, handshake flags and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            starve_q   <= '0;
            lsu_sel_q  <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            strb_q     <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            ifu_done_q <= 1'b0;
            lsu_done_q <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            ifu_done_q <= 1'b0;
            lsu_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (may_grant && lsu_win) begin
                        lsu_sel_q <= 1'b1;
                        addr_q    <= lsu_addr;
                        we_q      <= lsu_we;
                        wdata_q   <= lsu_wdata;
                        strb_q    <= lsu_strb;
                        if (ifu_valid && (starve_q < StarveMax)) begin
                            starve_q <= starve_q + 1'b1;
                        end
                        if (lsu_we) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= StAww;
                        end else begin
                            state_q <= StAr;
                        end
                    end else if (may_grant && ifu_win) begin
                        lsu_sel_q <= 1'b0;
                        addr_q    <= ifu_addr;
                        we_q      <= 1'b0;
                        wdata_q   <= '0;
                        strb_q    <= 4'hF;
                        starve_q  <= '0;
                        state_q   <= StAr;
                    end
                end
                StAr: begin
                    if (io_master_arready) begin
                        state_q <= StR;
                    end
                end
                StR: begin
                    if (io_master_rvalid) begin
                        rdata_q <= addr_q[2] ? io_master_rdata[63:32] : io_master_rdata[31:0];
                        err_q   <= (io_master_rresp != 2'b00);
                        if (lsu_sel_q) begin
                            lsu_done_q <= 1'b1;
                        end else begin
                            ifu_done_q <= 1'b1;
                        end
                        state_q <= StIdle;
                    end
                end
                StAww: begin
                    if (awvalid_q && io_master_awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wvalid_q && io_master_wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        state_q <= StB;
                    end
                end
                StB: begin
                    if (io_master_bvalid) begin
                        err_q      <= (io_master_bresp != 2'b00);
                        lsu_done_q <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ifu_done_o        = ifu_done_q;
    assign lsu_done_o        = lsu_done_q;
    assign rdata_o           = rdata_q;
    assign err_o             = err_q;

    assign io_master_araddr  = addr_q;
    assign io_master_arsize  = size_from_strb(strb_q);
    assign io_master_arvalid = (state_q == StAr);
    assign io_master_rready  = (state_q == StR);

    assign io_master_awaddr  = addr_q;
    assign io_master_awsize  = size_from_strb(strb_q);
    assign io_master_awvalid = awvalid_q;
    assign io_master_wdata   = {lane, lane};
    assign io_master_wstrb   = addr_q[2] ? {strb_sh, 4'b0000} : {4'b0000, strb_sh};
    assign io_master_wlast   = wvalid_q;
    assign io_master_wvalid  = wvalid_q;
    assign io_master_bready  = (state_q == StB);

    // we_q is kept for debug visibility of the granted transaction type.
    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_ysyx_bus_sched.sv
// Directed self-checking bench for ysyx_bus_sched with a hand-driven AXI slave.
module tb_ysyx_bus_sched;

    logic        clk;
    logic        rst;
    logic [31:0] ifu_addr;
    logic        ifu_valid;
    logic        ifu_done_o;
    logic [31:0] lsu_addr;
    logic        lsu_valid;
    logic        lsu_we;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_strb;
    logic        lsu_done_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int n_cmp = 0;
    int n_err = 0;

    ysyx_bus_sched #(
        .STARVE_MAX(4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ifu_addr          (ifu_addr),
        .ifu_valid         (ifu_valid),
        .ifu_done_o        (ifu_done_o),
        .lsu_addr          (lsu_addr),
        .lsu_valid         (lsu_valid),
        .lsu_we            (lsu_we),
        .lsu_wdata         (lsu_wdata),
        .lsu_strb          (lsu_strb),
        .lsu_done_o        (lsu_done_o),
        .rdata_o           (rdata_o),
        .err_o             (err_o),
        .io_master_araddr  (araddr),
        .io_master_arsize  (arsize),
        .io_master_arvalid (arvalid),
        .io_master_arready (arready),
        .io_master_rdata   (rdata),
        .io_master_rresp   (rresp),
        .io_master_rvalid  (rvalid),
        .io_master_rready  (rready),
        .io_master_awaddr  (awaddr),
        .io_master_awsize  (awsize),
        .io_master_awvalid (awvalid),
        .io_master_awready (awready),
        .io_master_wdata   (wdata),
        .io_master_wstrb   (wstrb),
        .io_master_wlast   (wlast),
        .io_master_wvalid  (wvalid),
        .io_master_wready  (wready),
        .io_master_bresp   (bresp),
        .io_master_bvalid  (bvalid),
        .io_master_bready  (bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ar();
        int n = 0;
        while (!arvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ar_wait", {63'd0, arvalid}, 64'd1);
    endtask

    task automatic wait_aw();
        int n = 0;
        while (!awvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("aw_wait", {63'd0, awvalid}, 64'd1);
    endtask

    // AR handshake then one R beat; returns on the negedge where done should be high.
    task automatic do_read(input logic [63:0] rd, input logic [1:0] resp);
        wait_ar();
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = rd;
        rresp   = resp;
        @(negedge clk);
        rvalid  = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ifu_done"}, {63'd0, ifu_done_o}, 64'd0);
        check({tag, "_lsu_done"}, {63'd0, lsu_done_o}, 64'd0);
        check({tag, "_rdata"}, {32'd0, rdata_o}, 64'd0);
        check({tag, "_err"}, {63'd0, err_o}, 64'd0);
        check({tag, "_arvalid"}, {63'd0, arvalid}, 64'd0);
        check({tag, "_rready"}, {63'd0, rready}, 64'd0);
        check({tag, "_awvalid"}, {63'd0, awvalid}, 64'd0);
        check({tag, "_wvalid"}, {63'd0, wvalid}, 64'd0);
        check({tag, "_bready"}, {63'd0, bready}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_order [10];
        logic [7:0] who;

        rst = 1'b1;
        ifu_addr = '0; ifu_valid = 1'b0;
        lsu_addr = '0; lsu_valid = 1'b0; lsu_we = 1'b0; lsu_wdata = '0; lsu_strb = 4'hF;
        arready = 1'b0; rdata = '0; rresp = '0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Both requesters valid continuously: LSU gets four in a row, then the IFU.
        exp_order = '{"L", "L", "L", "L", "I", "L", "L", "L", "L", "I"};
        ifu_addr  = 32'h0000_0200; ifu_valid = 1'b1;
        lsu_addr  = 32'h0000_0100; lsu_valid = 1'b1; lsu_we = 1'b0; lsu_strb = 4'hF;
        for (int i = 0; i < 10; i++) begin
            do_read(64'h0, 2'b00);
            who = lsu_done_o ? "L" : (ifu_done_o ? "I" : "?");
            check($sformatf("grant_%0d", i), {56'd0, who}, {56'd0, exp_order[i]});
        end
        ifu_valid = 1'b0;
        lsu_valid = 1'b0;
        @(negedge clk);

        // IFU fetch from the upper word of a doubleword.
        ifu_addr  = 32'h8000_0004; ifu_valid = 1'b1;
        wait_ar();
        check("ifu_araddr", {32'd0, araddr}, 64'h8000_0004);
        check("ifu_arsize", {61'd0, arsize}, 64'd2);
        do_read(64'h1122_3344_5566_7788, 2'b00);
        check("ifu_done", {63'd0, ifu_done_o}, 64'd1);
        check("ifu_no_lsu_done", {63'd0, lsu_done_o}, 64'd0);
        check("ifu_rdata", {32'd0, rdata_o}, 64'h1122_3344);
        check("ifu_err", {63'd0, err_o}, 64'd0);
        ifu_valid = 1'b0;
        @(negedge clk);
        check("ifu_done_one_cycle", {63'd0, ifu_done_o}, 64'd0);

        // Byte store at 0x0F03; AW completes three cycles before W.
        lsu_addr = 32'h0000_0F03; lsu_we = 1'b1; lsu_strb = 4'h1; lsu_wdata = 32'h0000_00AB;
        lsu_valid = 1'b1;
        wait_aw();
        check("st_awaddr", {32'd0, awaddr}, 64'h0F03);
        check("st_awsize", {61'd0, awsize}, 64'd0);
        check("st_wstrb", {56'd0, wstrb}, 64'h08);
        check("st_wdata", wdata, 64'hAB00_0000_AB00_0000);
        check("st_wvalid", {63'd0, wvalid}, 64'd1);
        check("st_wlast", {63'd0, wlast}, 64'd1);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        check("st_aw_dropped", {63'd0, awvalid}, 64'd0);
        check("st_w_held", {63'd0, wvalid}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        check("st_w_still_held", {63'd0, wvalid}, 64'd1);
        check("st_no_bready_yet", {63'd0, bready}, 64'd0);
        wready = 1'b1;
        @(negedge clk);
        wready = 1'b0;
        check("st_w_dropped", {63'd0, wvalid}, 64'd0);
        check("st_bready", {63'd0, bready}, 64'd1);
        bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk);
        bvalid = 1'b0;
        check("st_lsu_done", {63'd0, lsu_done_o}, 64'd1);
        check("st_err", {63'd0, err_o}, 64'd0);
        lsu_valid = 1'b0;
        @(negedge clk);
        check("st_done_one_cycle", {63'd0, lsu_done_o}, 64'd0);

        // Halfword store to the upper word; AW and W complete together; error response.
        lsu_addr = 32'h0000_0006; lsu_we = 1'b1; lsu_strb = 4'h3; lsu_wdata = 32'h0000_1234;
        lsu_valid = 1'b1;
        wait_aw();
        check("sh_awsize", {61'd0, awsize}, 64'd1);
        check("sh_wstrb", {56'd0, wstrb}, 64'hC0);
        check("sh_wdata", wdata, 64'h1234_0000_1234_0000);
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0;
        check("sh_aw_dropped", {63'd0, awvalid}, 64'd0);
        check("sh_w_dropped", {63'd0, wvalid}, 64'd0);
        check("sh_bready", {63'd0, bready}, 64'd1);
        bvalid = 1'b1; bresp = 2'b10;
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'b00;
        check("sh_lsu_done", {63'd0, lsu_done_o}, 64'd1);
        check("sh_err", {63'd0, err_o}, 64'd1);
        lsu_valid = 1'b0;
        @(negedge clk);

        // LSU load from the lower word with SLVERR.
        lsu_addr = 32'h0000_0010; lsu_we = 1'b0; lsu_strb = 4'hF; lsu_valid = 1'b1;
        do_read(64'hCAFE_BABE_DEAD_BEEF, 2'b10);
        check("ld_lsu_done", {63'd0, lsu_done_o}, 64'd1);
        check("ld_ifu_done", {63'd0, ifu_done_o}, 64'd0);
        check("ld_err", {63'd0, err_o}, 64'd1);
        check("ld_rdata", {32'd0, rdata_o}, 64'hDEAD_BEEF);
        lsu_valid = 1'b0;
        @(negedge clk);

        // Reset while waiting in R abandons the transaction and clears everything.
        ifu_addr = 32'h8000_0000; ifu_valid = 1'b1;
        wait_ar();
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check("rst_in_r_rready", {63'd0, rready}, 64'd1);
        rst = 1'b1;
        ifu_valid = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_mid");
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {63'd0, arvalid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
